// File: rtl/conjugation_ctrl_cba.sv
// Conjugation sequencer for the CBA literal/phase register array.
// One single-qubit Clifford gate is accepted per handshake. The controller
// rotates every row left once per column, so after num_qubit cycles the
// literal order is back where it started. On the cycle where the target
// column sits in the array's column 0, the conjugated literal is written back
// and the affected row phases are toggled.
module conjugation_ctrl_cba #(
  parameter int num_qubit = 4,
  parameter int QW        = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gate_valid,
  output logic                          gate_ready,
  input  logic [1:0]                    gate_type,
  input  logic [QW-1:0]                 gate_qubit,
  input  logic [0:num_qubit-1][1:0]     left_out,
  output logic                          ld_literal,
  output logic                          shift_rotate_literal,
  output logic                          rotate_update_literal,
  output logic [0:num_qubit-1][1:0]     update_literal,
  output logic [0:num_qubit-1]          ld_phase,
  output logic                          shift_toggle_phase,
  output logic                          done,
  output logic                          bad_qubit
);

  localparam int          CW        = (num_qubit > 1) ? $clog2(num_qubit) : 1;
  localparam logic [31:0] LAST_COL  = 32'(num_qubit - 1);
  localparam logic [31:0] NUM_COLS  = 32'(num_qubit);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate encoding: 0:H 1:S 2:X 3:Z. Literal code {x,z}: 00 I, 01 Z, 10 X, 11 Y.
  function automatic logic [1:0] conj_literal(input logic [1:0] gtype, input logic [1:0] lit);
    logic [1:0] res;
    case (gtype)
      2'd0:    res = {lit[0], lit[1]};          // H swaps X and Z
      2'd1:    res = {lit[1], lit[1] ^ lit[0]}; // S maps X to Y and Y to X
      2'd2:    res = lit;                       // Paulis leave the literal
      2'd3:    res = lit;
      default: res = lit;
    endcase
    return res;
  endfunction

  // Sign change of the conjugated literal, applied as a phase toggle.
  function automatic logic flip_phase(input logic [1:0] gtype, input logic [1:0] lit);
    logic res;
    case (gtype)
      2'd0:    res = lit[1] & lit[0];
      2'd1:    res = lit[1] & lit[0];
      2'd2:    res = lit[0];
      2'd3:    res = lit[1];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  state_t        state_r, state_next_s;
  logic [CW-1:0] cnt_r;
  logic [1:0]    type_r;
  logic [QW-1:0] qubit_r;
  logic          last_col_s;
  logic          target_col_s;
  logic          qubit_bad_s;

  assign last_col_s   = (32'(cnt_r) == LAST_COL);
  assign target_col_s = (32'(cnt_r) == 32'(qubit_r));
  assign qubit_bad_s  = (32'(qubit_r) >= NUM_COLS);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command latch and column counter; busy-time commands are not captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= {CW{1'b0}};
      type_r  <= 2'd0;
      qubit_r <= {QW{1'b0}};
    end else if (state_r == IDLE && gate_valid) begin
      cnt_r   <= {CW{1'b0}};
      type_r  <= gate_type;
      qubit_r <= gate_qubit;
    end else if (state_r == ROT && !last_col_s) begin
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Next-state and array control decode from the registered state.
  always_comb begin
    state_next_s          = state_r;
    gate_ready            = 1'b0;
    ld_literal            = 1'b0;
    shift_rotate_literal  = 1'b0;
    rotate_update_literal = 1'b0;
    update_literal        = '0;
    ld_phase              = '0;
    shift_toggle_phase    = 1'b0;
    done                  = 1'b0;
    bad_qubit             = 1'b0;
    case (state_r)
      IDLE: begin
        gate_ready = 1'b1;
        if (gate_valid) begin
          state_next_s = ROT;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROT: begin
        ld_literal           = 1'b1;
        shift_rotate_literal = 1'b1;
        shift_toggle_phase   = 1'b1;
        if (target_col_s) begin
          rotate_update_literal = 1'b1;
          for (int r = 0; r < num_qubit; r++) begin
            update_literal[r] = conj_literal(type_r, left_out[r]);
            ld_phase[r]       = flip_phase(type_r, left_out[r]);
          end
        end else begin
          rotate_update_literal = 1'b0;
        end
        if (last_col_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ROT;
        end
      end
      DONE: begin
        done         = 1'b1;
        bad_qubit    = qubit_bad_s;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conjugation_ctrl_cba.sv
// Self-checking bench for conjugation_ctrl_cba with num_qubit=4 and a widened
// qubit field so out-of-range targets can be issued.
module tb_conjugation_ctrl_cba;

  localparam int N  = 4;
  localparam int QW = 3;

  // Pauli codes {x,z}
  localparam logic [1:0] P_I = 2'd0;
  localparam logic [1:0] P_Z = 2'd1;
  localparam logic [1:0] P_X = 2'd2;
  localparam logic [1:0] P_Y = 2'd3;

  logic                  clk;
  logic                  rst;
  logic                  gate_valid;
  logic                  gate_ready;
  logic [1:0]            gate_type;
  logic [QW-1:0]         gate_qubit;
  logic [0:N-1][1:0]     left_out;
  logic                  ld_literal;
  logic                  shift_rotate_literal;
  logic                  rotate_update_literal;
  logic [0:N-1][1:0]     update_literal;
  logic [0:N-1]          ld_phase;
  logic                  shift_toggle_phase;
  logic                  done;
  logic                  bad_qubit;

  int n_checks = 0;
  int n_fail   = 0;

  conjugation_ctrl_cba #(.num_qubit(N), .QW(QW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .gate_valid            (gate_valid),
    .gate_ready            (gate_ready),
    .gate_type             (gate_type),
    .gate_qubit            (gate_qubit),
    .left_out              (left_out),
    .ld_literal            (ld_literal),
    .shift_rotate_literal  (shift_rotate_literal),
    .rotate_update_literal (rotate_update_literal),
    .update_literal        (update_literal),
    .ld_phase              (ld_phase),
    .shift_toggle_phase    (shift_toggle_phase),
    .done                  (done),
    .bad_qubit             (bad_qubit)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: Clifford conjugation of a Pauli, from the gate tables
  // H: X<->Z, Y->-Y   S: X->Y, Y->-X   X: Z->-Z, Y->-Y   Z: X->-X, Y->-Y
  // Returns {sign_flip, new_pauli}.
  function automatic logic [2:0] ref_conj(input logic [1:0] g, input logic [1:0] p);
    logic [2:0] r;
    r = {1'b0, p};
    case (g)
      2'd0: begin
        if (p == P_X)      r = {1'b0, P_Z};
        else if (p == P_Z) r = {1'b0, P_X};
        else if (p == P_Y) r = {1'b1, P_Y};
        else               r = {1'b0, P_I};
      end
      2'd1: begin
        if (p == P_X)      r = {1'b0, P_Y};
        else if (p == P_Y) r = {1'b1, P_X};
        else               r = {1'b0, p};
      end
      2'd2: r = {(p == P_Z || p == P_Y), p};
      2'd3: r = {(p == P_X || p == P_Y), p};
      default: r = {1'b0, p};
    endcase
    return r;
  endfunction

  // Timeline model: k=0 idle, k=1..N rotation of column k-1, k=N+1 done.
  task automatic check_model(input int k, input logic [1:0] g, input int q);
    logic [0:N-1][1:0] exp_upd;
    logic [0:N-1]      exp_ph;
    logic [2:0]        c;
    logic              rot;
    logic              tgt;
    rot = (k >= 1 && k <= N);
    tgt = rot && (k - 1 == q);
    exp_upd = '0;
    exp_ph  = '0;
    if (tgt) begin
      for (int r = 0; r < N; r++) begin
        c = ref_conj(g, left_out[r]);
        exp_upd[r] = c[1:0];
        exp_ph[r]  = c[2];
      end
    end
    check("rnd_ready", 32'(gate_ready), 32'(k == 0));
    check("rnd_ld_literal", 32'(ld_literal), 32'(rot));
    check("rnd_shift_rot", 32'(shift_rotate_literal), 32'(rot));
    check("rnd_shift_tog", 32'(shift_toggle_phase), 32'(rot));
    check("rnd_rot_upd", 32'(rotate_update_literal), 32'(tgt));
    check("rnd_update", 32'(update_literal), 32'(exp_upd));
    check("rnd_ld_phase", 32'(ld_phase), 32'(exp_ph));
    check("rnd_done", 32'(done), 32'(k == N + 1));
    check("rnd_bad", 32'(bad_qubit), 32'((k == N + 1) && (q >= N)));
  endtask

  typedef struct {
    logic [1:0]        gtype;
    logic [QW-1:0]     qubit;
    logic [0:N-1][1:0] col;
    logic [0:N-1][1:0] exp_upd;
    logic [0:N-1]      exp_ph;
    logic              exp_bad;
  } vec_t;

  vec_t vecs [6];

  // Apply one gate from the table, holding valid high while busy with
  // scrambled type/qubit to show that nothing is re-latched.
  task automatic run_vec(input vec_t v, input int idx);
    int q;
    q = int'(v.qubit);
    @(negedge clk);
    gate_valid = 1'b1;
    gate_type  = v.gtype;
    gate_qubit = v.qubit;
    left_out   = v.col;
    #1;
    check($sformatf("v%0d_ready_accept", idx), 32'(gate_ready), 32'd1);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      gate_type  = ~v.gtype;
      gate_qubit = v.qubit + 3'd1;
      if (k == N + 1) gate_valid = 1'b0;
      #1;
      if (k <= N) begin
        check($sformatf("v%0d_k%0d_ld_literal", idx, k), 32'(ld_literal), 32'd1);
        check($sformatf("v%0d_k%0d_ready", idx, k), 32'(gate_ready), 32'd0);
        check($sformatf("v%0d_k%0d_rot_upd", idx, k), 32'(rotate_update_literal), 32'(k - 1 == q));
        check($sformatf("v%0d_k%0d_update", idx, k), 32'(update_literal),
              (k - 1 == q) ? 32'(v.exp_upd) : 32'd0);
        check($sformatf("v%0d_k%0d_ld_phase", idx, k), 32'(ld_phase),
              (k - 1 == q) ? 32'(v.exp_ph) : 32'd0);
        check($sformatf("v%0d_k%0d_done", idx, k), 32'(done), 32'd0);
      end else begin
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_bad", idx), 32'(bad_qubit), 32'(v.exp_bad));
        check($sformatf("v%0d_done_ld", idx), 32'(ld_literal), 32'd0);
        check($sformatf("v%0d_done_ready", idx), 32'(gate_ready), 32'd0);
      end
    end
  endtask

  int m_k;
  logic [1:0] m_g;
  int m_q;

  // Main stimulus.
  initial begin
    vecs[0] = '{2'd0, 3'd1, {P_X, P_Z, P_Y, P_I}, {P_Z, P_X, P_Y, P_I}, 4'b0010, 1'b0};
    vecs[1] = '{2'd1, 3'd3, {P_X, P_Y, P_Z, P_I}, {P_Y, P_X, P_Z, P_I}, 4'b0100, 1'b0};
    vecs[2] = '{2'd2, 3'd0, {P_Z, P_X, P_Y, P_I}, {P_Z, P_X, P_Y, P_I}, 4'b1010, 1'b0};
    vecs[3] = '{2'd3, 3'd0, {P_Z, P_X, P_Y, P_I}, {P_Z, P_X, P_Y, P_I}, 4'b0110, 1'b0};
    vecs[4] = '{2'd0, 3'd5, {P_X, P_Y, P_Z, P_Y}, {P_I, P_I, P_I, P_I}, 4'b0000, 1'b1};
    vecs[5] = '{2'd2, 3'd4, {P_Y, P_Z, P_Y, P_Z}, {P_I, P_I, P_I, P_I}, 4'b0000, 1'b1};

    rst        = 1'b0;
    gate_valid = 1'b0;
    gate_type  = 2'd0;
    gate_qubit = '0;
    left_out   = '0;
    #12;
    check("rst_ready", 32'(gate_ready), 32'd1);
    check("rst_ld_literal", 32'(ld_literal), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("idle_ready", 32'(gate_ready), 32'd1);
      check("idle_ld_literal", 32'(ld_literal), 32'd0);
      check("idle_ld_phase", 32'(ld_phase), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // Table vectors, applied back to back.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    @(negedge clk);
    #1;
    check("post_table_ready", 32'(gate_ready), 32'd1);

    // Reset asserted during the third rotation cycle (cnt=2).
    gate_valid = 1'b1;
    gate_type  = 2'd0;
    gate_qubit = 3'd2;
    left_out   = {P_Y, P_Y, P_Y, P_Y};
    @(negedge clk);
    gate_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_rot_upd", 32'(rotate_update_literal), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ld_literal", 32'(ld_literal), 32'd0);
    check("midrst_rot_upd", 32'(rotate_update_literal), 32'd0);
    check("midrst_ld_phase", 32'(ld_phase), 32'd0);
    check("midrst_shift_tog", 32'(shift_toggle_phase), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_ready", 32'(gate_ready), 32'd1);
      check("post_rst_no_done", 32'(done), 32'd0);
    end

    // Randomized traffic against the timeline model.
    m_k = 0;
    m_g = 2'd0;
    m_q = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gate_valid = ($urandom_range(0, 1) == 1);
      gate_type  = 2'($urandom_range(0, 3));
      gate_qubit = 3'($urandom_range(0, 5));
      for (int r = 0; r < N; r++) left_out[r] = 2'($urandom_range(0, 3));
      #1;
      check_model(m_k, m_g, m_q);
      if (m_k == 0) begin
        if (gate_valid) begin
          m_k = 1;
          m_g = gate_type;
          m_q = int'(gate_qubit);
        end
      end else if (m_k == N + 1) begin
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
